// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the multi-pattern sequence detector.
// Slot configuration record plus width and mask helpers used across the slice.
package seq_det_pkg;

   localparam int PAT_MAX   = 32;
   localparam int LEN_MAX_W = 6;

   typedef struct packed {
      logic [PAT_MAX-1:0]   pat;
      logic [LEN_MAX_W-1:0] len;
   } slot_cfg_t;

   function automatic int idx_w(input int num_pat);
      return (num_pat > 1) ? $clog2(num_pat) : 1;
   endfunction

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   // Low L bits set; L=0 gives an empty mask.
   function automatic logic [PAT_MAX-1:0] len_mask(input logic [LEN_MAX_W-1:0] len);
      logic [PAT_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < PAT_MAX; i++)
         if (i < int'(len)) m[i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/seq_detector_multi_if.sv
// Bit-stream, configuration and hit/status bundle of the sequence detector.
// master = serial front end / config side, slave = detector.
interface seq_detector_multi_if #(
   parameter int NUM_PAT = 4,
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
);
   localparam int IDX_W = seq_det_pkg::idx_w(NUM_PAT);
   localparam int LEN_W = seq_det_pkg::len_w(MAX_LEN);

   logic                     i_valid;
   logic                     i_bit;
   logic                     i_clr;
   logic                     i_overlap;
   logic                     i_cfg_we;
   logic [IDX_W-1:0]         i_cfg_idx;
   logic [MAX_LEN-1:0]       i_cfg_pat;
   logic [LEN_W-1:0]         i_cfg_len;
   logic [NUM_PAT-1:0]       o_hit;
   logic                     o_hit_any;
   logic [IDX_W-1:0]         o_hit_id;
   logic [NUM_PAT*CNT_W-1:0] o_hit_cnt;

   modport master (
      output i_valid, i_bit, i_clr, i_overlap, i_cfg_we, i_cfg_idx, i_cfg_pat, i_cfg_len,
      input  o_hit, o_hit_any, o_hit_id, o_hit_cnt
   );

   modport slave (
      input  i_valid, i_bit, i_clr, i_overlap, i_cfg_we, i_cfg_idx, i_cfg_pat, i_cfg_len,
      output o_hit, o_hit_any, o_hit_id, o_hit_cnt
   );

endinterface

// File: rtl/seq_det_slot.sv
// One pattern slot: pat/len registers, compare against the shared history and,
// when SEQDET_COUNT_EN is defined, a saturating hit counter.
module seq_det_slot
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8
`ifdef SEQDET_COUNT_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_accept,
   input  logic [MAX_LEN-1:0]        i_hist,
   input  logic [len_w(MAX_LEN)-1:0] i_fill,
   input  logic                      i_cfg_sel,
   input  logic [MAX_LEN-1:0]        i_cfg_pat,
   input  logic [len_w(MAX_LEN)-1:0] i_cfg_len,
`ifdef SEQDET_COUNT_EN
   input  logic                      i_clr,
   output logic [CNT_W-1:0]          o_cnt,
`endif
   output logic                      o_match
);

   slot_cfg_t r_cfg;
   logic      w_en;
   logic      w_full;
   logic      w_eq;

   always_ff @(posedge clk) begin
      // NOTE: the config flops take reset too, so every slot comes up disabled.
      if (rst) begin
         r_cfg <= '0;
      end else if (i_cfg_sel) begin
         r_cfg.pat <= PAT_MAX'(i_cfg_pat);
         r_cfg.len <= LEN_MAX_W'(i_cfg_len);
      end
   end

   // Matching sees the pre-write config; a write lands for the next bit.
   assign w_en    = (r_cfg.len != '0) && (r_cfg.len <= LEN_MAX_W'(MAX_LEN));
   assign w_full  = LEN_MAX_W'(i_fill) >= r_cfg.len;
   assign w_eq    = ((PAT_MAX'(i_hist) ^ r_cfg.pat) & len_mask(r_cfg.len)) == '0;
   assign o_match = i_accept & w_en & w_full & w_eq;

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_cfg_sel || i_clr) begin
         r_cnt <= '0;
      end else if (o_match && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/seq_detector_multi.sv
// Multi-pattern serial sequence detector: shared history, NUM_PAT slots, priority
// encoder and registered hit outputs. Per-slot counters exist only with SEQDET_COUNT_EN.
module seq_detector_multi
   import seq_det_pkg::*;
#(
   parameter int NUM_PAT = 4,
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input logic                 clk,
   input logic                 rst,
   seq_detector_multi_if.slave bus
);

   localparam int IDX_W = idx_w(NUM_PAT);
   localparam int LEN_W = len_w(MAX_LEN);

   logic [MAX_LEN-1:0] r_hist;
   logic [MAX_LEN-1:0] w_hist_next;
   logic [LEN_W-1:0]   r_fill;
   logic [LEN_W-1:0]   w_fill_next;
   logic               w_accept;
   logic [NUM_PAT-1:0] w_match;
   logic [NUM_PAT-1:0] w_cfg_sel;
   logic [IDX_W-1:0]   w_first;
   logic [NUM_PAT-1:0] r_hit;
   logic               r_hit_any;
   logic [IDX_W-1:0]   r_hit_id;

   // clr drops the bit on the same edge, so it never reaches the slots.
   assign w_accept    = bus.i_valid & ~bus.i_clr;
   assign w_hist_next = {r_hist[MAX_LEN-2:0], bus.i_bit};
   assign w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;

   for (genvar p = 0; p < NUM_PAT; p++) begin : g_slot
      assign w_cfg_sel[p] = bus.i_cfg_we && (bus.i_cfg_idx == IDX_W'(p));

      seq_det_slot #(
         .MAX_LEN(MAX_LEN)
`ifdef SEQDET_COUNT_EN
         , .CNT_W(CNT_W)
`endif
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .i_accept  (w_accept),
         .i_hist    (w_hist_next),
         .i_fill    (w_fill_next),
         .i_cfg_sel (w_cfg_sel[p]),
         .i_cfg_pat (bus.i_cfg_pat),
         .i_cfg_len (bus.i_cfg_len),
`ifdef SEQDET_COUNT_EN
         .i_clr     (bus.i_clr),
         .o_cnt     (bus.o_hit_cnt[p*CNT_W +: CNT_W]),
`endif
         .o_match   (w_match[p])
      );
   end

`ifndef SEQDET_COUNT_EN
   assign bus.o_hit_cnt = {(NUM_PAT*CNT_W){1'b0}};
`endif

   always_comb begin
      // NOTE: blocking assignments here; the downward scan leaves the lowest hit index last.
      w_first = '0;
      for (int p = NUM_PAT - 1; p >= 0; p--)
         if (w_match[p]) w_first = IDX_W'(p);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist    <= '0;
         r_fill    <= '0;
         r_hit     <= '0;
         r_hit_any <= 1'b0;
         r_hit_id  <= '0;
      end else begin
         r_hit     <= w_match;
         r_hit_any <= |w_match;
         r_hit_id  <= w_first;
         if (bus.i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
         end else if (bus.i_valid) begin
            r_hist <= w_hist_next;
            // Non-overlapping: any hit forces L fresh bits before the next match.
            r_fill <= (!bus.i_overlap && (|w_match)) ? '0 : w_fill_next;
         end
      end
   end

   assign bus.o_hit     = r_hit;
   assign bus.o_hit_any = r_hit_any;
   assign bus.o_hit_id  = r_hit_id;

endmodule

// File: doc/seq_detector_multi.md
# seq_detector_multi

Parametrised multi-pattern serial sequence detector, the successor to the team's fixed-encoding sequence-detector FSMs. It watches a serial bit stream qualified by a valid strobe and matches it against NUM_PAT runtime-programmable patterns of up to MAX_LEN bits each. It supports overlapping and non-overlapping matching, and keeps per-pattern saturating hit counters. It sits between a serial front end and a status/interrupt block.

## Interface
- NUM_PAT, 4, number of independent patterns (1..16)
- MAX_LEN, 8, maximum pattern length in bits (2..32)
- CNT_W, 8, width of each hit counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_bit is accepted on this clock edge
- in_bit  in  1  serial data bit
- clr  in  1  synchronous clear of history and counters; patterns are kept
- overlap  in  1  1 = overlapping matches; 0 = non-overlapping
- cfg_we  in  1  write one pattern slot
- cfg_idx  in  $clog2(NUM_PAT)  slot being written
- cfg_pat  in  MAX_LEN  pattern bits; bit [L-1] is the oldest bit, bit [0] the newest
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length L; 0 or >MAX_LEN disables the slot
- hit  out  NUM_PAT  one-cycle pulse per slot on a match
- hit_any  out  1  OR of hit
- hit_id  out  $clog2(NUM_PAT)  lowest index set in hit; 0 when hit_any=0
- hit_cnt  out  NUM_PAT*CNT_W  per-slot counters, slot p at [p*CNT_W +: CNT_W]

## Operation
- Reset values:
  - history, fill count, all patterns and lengths: 0, so all slots are disabled.
  - hit, hit_any, hit_id, hit_cnt: 0.
- History: a MAX_LEN-bit shift register, newest bit at [0], with fill count `fill` saturating at MAX_LEN.
- Each accepted bit shifts into [0] and increments `fill`.
- Slot p matches on an accepted bit when all of the following hold:
  - the slot is enabled;
  - the post-shift fill is ≥ L;
  - the post-shift history[L-1:0] equals pat[L-1:0].
- Overlapping mode: history is never cleared by a match. Pattern 0101 on input 0101 01 gives two hits.
- Non-overlapping mode: any match by any slot sets fill to 0 and leaves the history contents as don't-care. The next match needs L fresh bits.
- Multiple slots may hit on the same bit. All of their hit bits assert together, and hit_id reports the lowest index.
- Counters:
  - a counter increments by 1 per hit and saturates at 2^CNT_W-1;
  - cfg_we to slot p zeroes counter p;
  - clr zeroes all counters.
- Simultaneous events:
  - clr together with in_valid: clr wins. The bit is dropped, there is no hit, and history and fill are cleared.
  - cfg_we together with in_valid: matching of that bit uses the old configuration, and the new configuration applies from the next accepted bit. If that bit hits the written slot, the counter reads 0 afterwards, because the config write wins.
  - rst overrides everything.
- in_valid=0: history, fill and counters hold, and hit is 0 that cycle.

## Timing
- hit, hit_any and hit_id are registered. They assert in the cycle after the edge that accepts the matching bit, for exactly one cycle.
- hit_cnt updates on the same edge that hit rises, so it is visible together with hit.
- One bit per clock is accepted at full throughput, with no backpressure.
- A config write is visible for matching on the edge after cfg_we.

## Configuration
- SEQDET_COUNT_EN:
  - Defined: counters exist as described above.
  - Undefined: no counter flops are built, hit_cnt is tied to 0, and cfg_we/clr affect only patterns and history.

## Structure
- Package seq_det_pkg holds:
  - the slot configuration typedef (pat, len);
  - the localparams for index and length widths;
  - a function that returns the mask for L.
- Sub-module seq_det_slot, instantiated NUM_PAT times, holds:
  - the slot's pat/len registers;
  - the compare against shared history;
  - the saturating counter.
- The top holds history, fill, the non-overlap clear, the priority encoder and the output registers.

## Test plan
- Reset, then slot0 = 010 (L=3), overlap=1; stream 0,1,0,1,0 → hit[0] pulses after bits 3 and 5; hit_cnt[0]=2.
- Slot1 = 0110 (L=4), overlap=0; stream 0110110 → one hit only, after bit 4; the trailing 110 gives no hit.
- Slot0 = 10, slot2 = 110 (L=3); stream 110 → hit=0b101 in one cycle, hit_id=0, both counters incremented.
- CNT_W=2; 5 matches on slot0 → hit_cnt[0] holds 3; cfg_we to slot0 → 0 the next cycle.
- clr asserted with the completing bit of 010 → no hit, counters 0, and a fresh 010 is needed to hit.
- rst mid-stream after 01 of 010, then 0 → no hit; all slots disabled and all outputs 0.
